rob_reorder_ctrl: RTL and testbench

//  Reorder-buffer control stage wrapped around the rob_gram_sdp payload RAM.
//  - Allocates sequential tags to outgoing requests.
//  - Accepts out-of-order completions keyed by tag and writes them into the RAM.
//  - Drains payloads strictly in allocation order through a valid/ready output.
//  - Sits between the CCI-P response path (upstream) and the in-order AFU return port (downstream).

---
 rtl/ccip_rob_pkg.sv | 12 +
 rtl/rob_gram_sdp.sv | 21 ++
 rtl/rob_reorder_ctrl.sv | 88 ++++++++
 tb/tb_rob_reorder_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ccip_rob_pkg.sv
// ccip_rob_pkg: shared widths and types for the reorder-buffer control slice
package ccip_rob_pkg;
    localparam int ROB_TAG_W  = 4;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_DEPTH  = 1 << ROB_TAG_W;
    function automatic int count_w(input int tag_w);
        return tag_w + 1;
    endfunction
    typedef logic [ROB_TAG_W-1:0]          tag_t;
    typedef logic [ROB_DATA_W-1:0]         data_t;
    typedef logic [count_w(ROB_TAG_W)-1:0] count_t;
endpackage

// File: rtl/rob_gram_sdp.sv
// rob_gram_sdp: simple dual-port payload RAM with a registered read, contents not reset
module rob_gram_sdp
    import ccip_rob_pkg::*;
#(
    parameter int TAG_W  = ROB_TAG_W,
    parameter int DATA_W = ROB_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [TAG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [TAG_W-1:0]  raddr,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [1 << TAG_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
        if (re) dout <= mem[raddr];
    end
endmodule

// File: rtl/rob_reorder_ctrl.sv
// rob_reorder_ctrl: allocates tags, absorbs out-of-order completions into the payload RAM
// and drains them in allocation order through a 2-entry output buffer.
module rob_reorder_ctrl
    import ccip_rob_pkg::*;
#(
    parameter int TAG_W  = ROB_TAG_W,
    parameter int DATA_W = ROB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cpl_valid,
    input  logic [TAG_W-1:0]  cpl_tag,
    input  logic [DATA_W-1:0] cpl_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              cpl_err
);
    localparam int DEPTH = 1 << TAG_W;
    localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);
    localparam logic [DEPTH-1:0] ONE = DEPTH'(1);
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d, rel;
    logic [TAG_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [1:0]        occ_q, occ_d, occ_left;
    logic [DATA_W-1:0] ob0_q, ob0_d, ob1_q, ob1_d, ram_dout;
    logic              inflight_q, err_q, err_d, pop, issue, in_range;
    assign alloc_gnt = alloc_req && !full;
    assign alloc_tag = head_q;
    assign count     = count_q;
    assign full      = count_q == CNT_FULL;
    assign empty     = count_q == '0;
    assign cpl_err   = err_q;
    assign out_valid = occ_q != 2'd0;
    assign out_data  = ob0_q;
    assign pop       = out_valid && out_ready;
    assign occ_left  = occ_q - {1'b0, pop};
    // Issue only if the read result is guaranteed a free obuf slot when it lands.
    assign issue     = vld_q[tail_q] && !empty && (occ_left + {1'b0, inflight_q}) < 2'd2;
    assign rel       = cpl_tag - tail_q;
    assign in_range  = {1'b0, rel} < count_q;
    assign err_d     = err_q || (cpl_valid && (vld_q[cpl_tag] || !in_range));
    assign head_d    = alloc_gnt ? head_q + TAG_W'(1) : head_q;
    assign tail_d    = issue ? tail_q + TAG_W'(1) : tail_q;
    assign count_d   = count_q + (TAG_W+1)'(alloc_gnt) - (TAG_W+1)'(issue);
    assign vld_d     = (vld_q & ~(issue ? ONE << tail_q : '0)) | (cpl_valid ? ONE << cpl_tag : '0);
    assign occ_d     = occ_left + {1'b0, inflight_q};
    assign ob0_d     = (inflight_q && occ_left == 2'd0) ? ram_dout : pop ? ob1_q : ob0_q;
    assign ob1_d     = (inflight_q && occ_left == 2'd1) ? ram_dout : ob1_q;
    rob_gram_sdp #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .we    (cpl_valid),
        .waddr (cpl_tag),
        .din   (cpl_data),
        .re    (issue),
        .raddr (tail_q),
        .dout  (ram_dout)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            vld_q      <= '0;
            occ_q      <= '0;
            ob0_q      <= '0;
            ob1_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            vld_q      <= vld_d;
            occ_q      <= occ_d;
            ob0_q      <= ob0_d;
            ob1_q      <= ob1_d;
            inflight_q <= issue;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_rob_reorder_ctrl.sv
// tb_rob_reorder_ctrl: directed scoreboard bench for the reorder-buffer control stage
module tb_rob_reorder_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_req = 1'b0;
    logic        alloc_gnt;
    logic [3:0]  alloc_tag;
    logic        cpl_valid = 1'b0;
    logic [3:0]  cpl_tag = '0;
    logic [31:0] cpl_data = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [4:0]  count;
    logic        full, empty, cpl_err;
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    int          head_m = 0;
    logic [31:0] data_m [16];
    logic [31:0] exp_q [$];

    rob_reorder_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_tag (alloc_tag),
        .cpl_valid (cpl_valid),
        .cpl_tag   (cpl_tag),
        .cpl_data  (cpl_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .cpl_err   (cpl_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        exp_q.delete();
        head_m = 0;
    endtask

    task automatic alloc_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            alloc_req = 1'b1;
            #1;
            chk("alloc_gnt", alloc_gnt, 1);
            chk("alloc_tag", alloc_tag, head_m);
            data_m[head_m] = base + head_m;
            exp_q.push_back(base + head_m);
            head_m = (head_m + 1) % 16;
            cycle();
        end
        alloc_req = 1'b0;
    endtask

    task automatic cpl(input int tag);
        cpl_valid = 1'b1;
        cpl_tag   = 4'(tag);
        cpl_data  = data_m[tag];
        cycle();
        cpl_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || !empty); i++) cycle();
        chk(tag, exp_q.size(), 0);
        chk({tag, "_empty"}, empty, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) chk("out_extra", out_valid, 0);
            else chk("out_data", out_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int p0;
        // 1: reset state and fill
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_cpl_err", cpl_err, 0);
        alloc_n(16, 32'hCAFE_0000);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        alloc_req = 1'b1;
        #1;
        chk("full_gnt", alloc_gnt, 0);
        cycle();
        alloc_req = 1'b0;
        chk("full_count_hold", count, 16);
        chk("full_tag_hold", alloc_tag, 0);
        // 2: reverse-order completions, in-order drain at full rate
        out_ready = 1'b1;
        for (int t = 15; t >= 0; t--) cpl(t);
        chk("lat_e0", out_valid, 0);
        cycle();
        chk("lat_e1", out_valid, 0);
        cycle();
        chk("lat_e2_valid", out_valid, 1);
        chk("lat_e2_data", out_data, 32'hCAFE_0000);
        for (int i = 0; i < 16; i++) cycle();
        chk("thru_drained", exp_q.size(), 0);
        chk("thru_pops", pops, 16);
        chk("thru_empty", empty, 1);
        chk("thru_err", cpl_err, 0);
        // 3: backpressure holds two reads in flight, then releases
        out_ready = 1'b0;
        alloc_n(16, 32'hCAFE_1000);
        for (int t = 0; t < 16; t++) cpl(t);
        for (int i = 0; i < 5; i++) cycle();
        chk("bp_count", count, 14);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 32'hCAFE_1000);
        cycle();
        cycle();
        chk("bp_data_stable", out_data, 32'hCAFE_1000);
        chk("bp_count_stable", count, 14);
        p0 = pops;
        out_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_pops", pops - p0, 16);
        // 4: wrap-around drain
        alloc_n(12, 32'h4000_0000);
        for (int t = 11; t >= 0; t--) cpl(t);
        wait_drain("wrap_a");
        alloc_n(8, 32'h5000_0000);
        chk("wrap_head", alloc_tag, 4);
        for (int k = 0; k < 8; k++) cpl((3 - k + 16) % 16);
        wait_drain("wrap_b");
        chk("wrap_count", count, 0);
        chk("wrap_err", cpl_err, 0);
        // 5: duplicate completion and completion while empty
        alloc_n(2, 32'h6000_0000);
        cpl(5);
        chk("dup_first", cpl_err, 0);
        cpl(5);
        chk("dup_second", cpl_err, 1);
        cpl(4);
        wait_drain("dup_drain");
        chk("dup_sticky", cpl_err, 1);
        do_reset();
        chk("err_rst_clear", cpl_err, 0);
        data_m[0] = 32'hDEAD_BEEF;
        cpl(0);
        chk("empty_cpl_err", cpl_err, 1);
        cycle();
        cycle();
        chk("empty_cpl_sticky", cpl_err, 1);
        // 6: reset one cycle after a read issue with entries pending
        do_reset();
        out_ready = 1'b0;
        alloc_n(4, 32'h7000_0000);
        cpl(1);
        cpl(2);
        cpl(3);
        cpl(0);
        cycle();
        rst = 1'b1;
        cycle();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        rst = 1'b0;
        exp_q.delete();
        head_m = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("late_valid", out_valid, 0);
            chk("late_data", out_data, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
